// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch stage.
//   XLEN           : address / instruction width
//   INSTR_BYTES    : bytes per instruction word (PC increment)
//   fetch_state_t  : fetch FSM states (REQ, WAIT, DROP)
//   fetch_entry_t  : queue payload {pc, instr}
package fetch_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned ENTRY_W     = 2 * XLEN;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} entries.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   flush        : empty the queue (pointers and count to zero)
//   push, data   : write an entry (caller guarantees space)
//   pop          : drop the head entry (caller guarantees non-empty)
//   count        : number of valid entries
//   head         : entry at the read pointer, straight from storage
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 push,
    input  fetch_entry_t         data,
    input  logic                 pop,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t         head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    fetch_entry_t     mem [DEPTH];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read at a time to
// instruction memory, queues returned words with their PCs for the datapath,
// and restarts on redirect while discarding responses from the old stream.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   imem_req/imem_addr/imem_gnt      : request handshake to instruction memory
//   imem_rvalid/imem_rdata           : response from instruction memory
//   redirect/redirect_pc             : taken branch/jump restart
//   instr_valid/instr/instr_pc       : queue head toward the datapath
//   instr_ready                      : datapath consumes the head
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready
);

    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t    state;
    fetch_state_t    next_state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tag;
    logic [CNT_W-1:0] count;
    logic            space;
    logic            fire;
    logic            push;
    logic            pop;
    fetch_entry_t    push_data;
    fetch_entry_t    head;

    assign space = (count < CNT_W'(QUEUE_DEPTH));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= REQ;
        end else begin
            state <= next_state;
        end
    end

    // Next state, request and push decode; redirect overrides the rest.
    always_comb begin
        next_state = state;
        imem_req   = 1'b0;
        fire       = 1'b0;
        push       = 1'b0;
        case (state)
            REQ: begin
                imem_req = space & ~reset;
                fire     = imem_req & imem_gnt;
                if (fire) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    push       = 1'b1;
                    next_state = REQ;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    next_state = REQ;
                end
            end
            default: begin
                next_state = REQ;
            end
        endcase
        if (redirect) begin
            push = 1'b0;
            // A granted request still owes a response; it must be swallowed.
            if ((state == REQ && fire) || (state == WAIT && !imem_rvalid)) begin
                next_state = DROP;
            end
        end
    end

    // Fetch PC and the address tag of the outstanding request.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc  <= RESET_PC;
            tag <= '0;
        end else begin
            if (redirect) begin
                pc <= {redirect_pc[XLEN-1:2], 2'b00};
            end else if (fire) begin
                pc <= pc + XLEN'(INSTR_BYTES);
            end
            if (fire) begin
                tag <= pc;
            end
        end
    end

    assign imem_addr   = pc;
    assign instr_valid = (count != '0);
    assign pop         = instr_valid & instr_ready & ~redirect;
    assign push_data   = '{pc: tag, instr: imem_rdata};

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .flush (redirect),
        .push  (push),
        .data  (push_data),
        .pop   (pop),
        .count (count),
        .head  (head)
    );

    assign instr    = head.instr;
    assign instr_pc = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit. A second instance with
// RESET_PC = 32'hFFFF_FFFC shares all inputs to observe PC wrap-around.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_ready;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic        w_instr_valid;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;

    int checks   = 0;
    int failures = 0;

    // Memory model knobs.
    bit          gnt_en   = 1'b1;
    bit          resp_en  = 1'b1;
    bit          force_rv = 1'b0;
    bit          pend     = 1'b0;
    logic [31:0] pend_addr = '0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .QUEUE_DEPTH(2)) u_wrap (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (w_imem_req),
        .imem_addr   (w_imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (w_instr_valid),
        .instr       (w_instr),
        .instr_pc    (w_instr_pc),
        .instr_ready (instr_ready)
    );

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Memory: grant/response driven just after the edge, handshake observed at negedge.
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            imem_gnt    = gnt_en;
            imem_rvalid = (pend & resp_en) | force_rv;
            imem_rdata  = force_rv ? 32'hDEAD_BEEF : rdata_of(pend_addr);
            @(negedge clk);
            if (imem_rvalid) pend = 1'b0;
            if (imem_req && imem_gnt) begin
                pend      = 1'b1;
                pend_addr = imem_addr;
            end
            if (reset) pend = 1'b0;
        end
    end

    // Returns at posedge+1 of the first cycle with reset low.
    task automatic do_reset(input bit ready, input bit chk);
        cyc();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        force_rv    = 1'b0;
        gnt_en      = 1'b1;
        resp_en     = 1'b1;
        instr_ready = ready;
        repeat (2) cyc();
        settle();
        if (chk) begin
            check_eq("rst_req",    32'(imem_req), 32'd0);
            check_eq("rst_valid",  32'(instr_valid), 32'd0);
            check_eq("rst_instr",  instr, 32'd0);
            check_eq("rst_pc",     instr_pc, 32'd0);
            check_eq("rst_addr",   imem_addr, 32'h0000_0000);
            check_eq("rst_waddr",  w_imem_addr, 32'hFFFF_FFFC);
        end
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;

        // Streaming fetch with immediate grant and 1-cycle response.
        do_reset(1'b1, 1'b1);
        settle();
        check_eq("t1_req_first",  32'(imem_req), 32'd1);
        check_eq("t1_addr_first", imem_addr, 32'h0);
        check_eq("t1_wreq_first", 32'(w_imem_req), 32'd1);
        check_eq("t1_waddr_first", w_imem_addr, 32'hFFFF_FFFC);
        cyc(); settle();
        check_eq("t1_req_wait",   32'(imem_req), 32'd0);
        check_eq("t1_valid_wait", 32'(instr_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(); settle();
            check_eq("t1_valid",  32'(instr_valid), 32'd1);
            check_eq("t1_pc",     instr_pc, 32'(4 * k));
            check_eq("t1_instr",  instr, rdata_of(32'(4 * k)));
            check_eq("t1_addr",   imem_addr, 32'(4 * (k + 1)));
            check_eq("t1_wvalid", 32'(w_instr_valid), 32'd1);
            check_eq("t1_wpc",    w_instr_pc, 32'hFFFF_FFFC + 32'(4 * k));
            check_eq("t1_winstr", w_instr, rdata_of(32'(4 * k)));
            check_eq("t1_waddr",  w_imem_addr, 32'hFFFF_FFFC + 32'(4 * (k + 1)));
            cyc(); settle();
            check_eq("t1_gap",    32'(instr_valid), 32'd0);
        end

        // Backpressure: queue fills at two entries, then drains and resumes.
        do_reset(1'b0, 1'b0);
        cyc(); cyc(); settle();
        check_eq("t2_valid_c2", 32'(instr_valid), 32'd1);
        check_eq("t2_addr_c2",  imem_addr, 32'h4);
        cyc(); cyc(); settle();
        check_eq("t2_req_full", 32'(imem_req), 32'd0);
        check_eq("t2_pc_full",  instr_pc, 32'h0);
        cyc(); settle();
        check_eq("t2_req_hold", 32'(imem_req), 32'd0);
        cyc();
        instr_ready = 1'b1;
        settle();
        check_eq("t2_drain0",   instr_pc, 32'h0);
        check_eq("t2_req_c6",   32'(imem_req), 32'd0);
        cyc(); settle();
        check_eq("t2_drain1",   instr_pc, 32'h4);
        check_eq("t2_req_res",  32'(imem_req), 32'd1);
        check_eq("t2_addr_res", imem_addr, 32'h8);
        cyc(); settle();
        check_eq("t2_empty",    32'(instr_valid), 32'd0);
        cyc(); settle();
        check_eq("t2_pc8",      instr_pc, 32'h8);
        check_eq("t2_valid8",   32'(instr_valid), 32'd1);

        // Redirect while waiting: late response is dropped.
        do_reset(1'b1, 1'b0);
        resp_en = 1'b0;
        cyc();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        settle();
        check_eq("t3_req_wait", 32'(imem_req), 32'd0);
        cyc();
        redirect = 1'b0;
        resp_en  = 1'b1;
        settle();
        check_eq("t3_valid_drop", 32'(instr_valid), 32'd0);
        check_eq("t3_req_drop",   32'(imem_req), 32'd0);
        cyc(); settle();
        check_eq("t3_req_new",    32'(imem_req), 32'd1);
        check_eq("t3_addr_new",   imem_addr, 32'h0000_0100);
        check_eq("t3_valid_new",  32'(instr_valid), 32'd0);
        cyc(); cyc(); settle();
        check_eq("t3_valid_100",  32'(instr_valid), 32'd1);
        check_eq("t3_pc_100",     instr_pc, 32'h0000_0100);
        check_eq("t3_instr_100",  instr, rdata_of(32'h0000_0100));

        // Redirect with a response and a pop in the same cycle; then in REQ with grant.
        do_reset(1'b0, 1'b0);
        cyc(); cyc(); cyc();
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        settle();
        check_eq("t4_pre_valid", 32'(instr_valid), 32'd1);
        check_eq("t4_pre_pc",    instr_pc, 32'h0);
        cyc();
        redirect = 1'b0;
        settle();
        check_eq("t4_flushed",   32'(instr_valid), 32'd0);
        check_eq("t4_req",       32'(imem_req), 32'd1);
        check_eq("t4_addr",      imem_addr, 32'h0000_0200);
        cyc(); cyc();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        settle();
        check_eq("t4_pc_200",    instr_pc, 32'h0000_0200);
        check_eq("t4_addr_204",  imem_addr, 32'h0000_0204);
        cyc();
        redirect = 1'b0;
        settle();
        check_eq("t4_drop_req",  32'(imem_req), 32'd0);
        check_eq("t4_drop_valid", 32'(instr_valid), 32'd0);
        cyc(); settle();
        check_eq("t4_req_300",   32'(imem_req), 32'd1);
        check_eq("t4_addr_300",  imem_addr, 32'h0000_0300);
        check_eq("t4_valid_300", 32'(instr_valid), 32'd0);

        // Reset during WAIT, then a stray response in REQ.
        do_reset(1'b1, 1'b0);
        cyc();
        reset = 1'b1;
        settle();
        check_eq("t6_req_rst",   32'(imem_req), 32'd0);
        cyc(); settle();
        check_eq("t6_req_rst2",  32'(imem_req), 32'd0);
        check_eq("t6_valid_rst", 32'(instr_valid), 32'd0);
        cyc();
        reset    = 1'b0;
        gnt_en   = 1'b0;
        force_rv = 1'b1;
        settle();
        check_eq("t6_req_rel",   32'(imem_req), 32'd1);
        check_eq("t6_addr_rel",  imem_addr, 32'h0);
        cyc();
        force_rv = 1'b0;
        gnt_en   = 1'b1;
        settle();
        check_eq("t6_stray",     32'(instr_valid), 32'd0);
        check_eq("t6_addr_keep", imem_addr, 32'h0);
        cyc(); cyc(); settle();
        check_eq("t6_valid",     32'(instr_valid), 32'd1);
        check_eq("t6_pc",        instr_pc, 32'h0);
        check_eq("t6_instr",     instr, rdata_of(32'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
